// File: rtl/mem_req_ctrl.sv
// Request FIFO feeding a memory sequencer: each op drives a two-cycle strobe; reads return a held response.
// Define MEM_REQ_CTRL_LEVEL_EN to add the LEVEL output (current FIFO occupancy).
package mem_req_ctrl_pkg;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 8;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;
endpackage

module mem_req_ctrl
   import mem_req_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              mem_r,
   output logic              mem_w,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_i,
   input  logic [DATA_W-1:0] mem_o,
   output logic              busy
`ifdef MEM_REQ_CTRL_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] level
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, CMD1, CMD2, RSP} state_t;

   state_t            state_q, state_d;
   req_t              fifo_mem [DEPTH];
   req_t              head;
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              push, pop;
   logic              ready_d, busy_d;
   logic              mem_r_d, mem_w_d, rsp_valid_d;
   logic [ADDR_W-1:0] mem_adr_d, rsp_addr_d;
   logic [DATA_W-1:0] mem_i_d, rsp_data_d;

   // Acceptance is gated only by the registered ready, so a same-cycle pop never admits a push when full.
   assign push    = req_valid & req_ready;
   assign head    = fifo_mem[rptr_q];
   assign count_d = count_q + CW'(push) - CW'(pop);
   assign ready_d = (count_d != CW'(DEPTH));
   assign busy_d  = (state_d != IDLE) || (count_d != '0);

   // Payload storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr_q] <= req_t'({req_wr, req_addr, req_data});
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Next state and next registered outputs; a pop always launches the head op into CMD1.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      mem_r_d     = 1'b0;
      mem_w_d     = 1'b0;
      mem_adr_d   = mem_adr;
      mem_i_d     = mem_i;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;
      rsp_addr_d  = rsp_addr;
      case (state_q)
         IDLE: pop = (count_q != '0);
         CMD1: begin
            state_d = CMD2;
            mem_r_d = mem_r;
            mem_w_d = mem_w;
         end
         CMD2: begin
            if (mem_w) begin
               state_d = IDLE;
               pop     = (count_q != '0);
            end else begin
               state_d     = RSP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = mem_o;
               rsp_addr_d  = mem_adr;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               pop     = (count_q != '0);
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         state_d   = CMD1;
         mem_r_d   = ~head.wr;
         mem_w_d   = head.wr;
         mem_adr_d = head.addr;
         mem_i_d   = head.data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
         mem_r     <= 1'b0;
         mem_w     <= 1'b0;
         mem_adr   <= '0;
         mem_i     <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_ready <= ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rsp_addr  <= rsp_addr_d;
         mem_r     <= mem_r_d;
         mem_w     <= mem_w_d;
         mem_adr   <= mem_adr_d;
         mem_i     <= mem_i_d;
         busy      <= busy_d;
      end
   end

`ifdef MEM_REQ_CTRL_LEVEL_EN
   assign level = count_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed scenarios plus random traffic, checked against a transaction-level model.
module tb_mem_req_ctrl;
   localparam int unsigned DEPTH = 4;

   typedef struct packed { logic wr; logic [2:0] addr; logic [7:0] data; } op_t;
   typedef struct packed { logic [2:0] addr; logic [7:0] data; } rsp_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       req_valid, req_ready, req_wr;
   logic [2:0] req_addr;
   logic [7:0] req_data;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic [2:0] rsp_addr;
   logic       mem_r, mem_w;
   logic [2:0] mem_adr;
   logic [7:0] mem_i, mem_o;
   logic       busy;
`ifdef MEM_REQ_CTRL_LEVEL_EN
   logic [$clog2(DEPTH):0] level;
`endif

   logic [7:0] mem [8];
   logic       mem_clr;

   int         tests = 0;
   int         fails = 0;
   op_t        ops[$];
   rsp_t       rsps[$];
   op_t        cur;
   bit         phase;
   bit         ready_armed;
   logic [7:0] ref_mem [8];

   mem_req_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
      .mem_r(mem_r), .mem_w(mem_w), .mem_adr(mem_adr), .mem_i(mem_i), .mem_o(mem_o),
      .busy(busy)
`ifdef MEM_REQ_CTRL_LEVEL_EN
      , .level(level)
`endif
   );

   always #5 clk = ~clk;

   // Simple 8x8 memory device driven by the strobes.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      end else if (mem_w) begin
         mem[mem_adr] <= mem_i;
      end
   end
   assign mem_o = mem[mem_adr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_op();
      chk("op_w", 32'(mem_w), 32'(cur.wr));
      chk("op_r", 32'(mem_r), 32'(!cur.wr));
      chk("op_adr", 32'(mem_adr), 32'(cur.addr));
      if (cur.wr) chk("op_data", 32'(mem_i), 32'(cur.data));
   endtask

   // Called mid-cycle: compares outputs with the model, then records this cycle's handshakes.
   task automatic monitor();
      op_t  o;
      rsp_t r;
      chk("strobe_excl", 32'(mem_r & mem_w), 32'd0);
      if ((mem_r | mem_w) && !phase) begin
         chk("issue_has_op", 32'(ops.size() != 0), 32'd1);
         if (ops.size() != 0) begin
            cur = ops.pop_front();
            if (cur.wr) begin
               ref_mem[cur.addr] = cur.data;
            end else begin
               r.addr = cur.addr;
               r.data = ref_mem[cur.addr];
               rsps.push_back(r);
            end
         end
         check_op();
         phase = 1'b1;
      end else if (mem_r | mem_w) begin
         check_op();
         phase = 1'b0;
      end else begin
         chk("strobe_two_cycles", 32'(phase), 32'd0);
         phase = 1'b0;
      end
      if (ready_armed) chk("req_ready", 32'(req_ready), 32'(ops.size() < int'(DEPTH)));
      if (ops.size() != 0 || phase) chk("busy_active", 32'(busy), 32'd1);
`ifdef MEM_REQ_CTRL_LEVEL_EN
      chk("level", 32'(level), 32'(ops.size()));
`endif
      if (rsp_valid) begin
         chk("rsp_expected", 32'(rsps.size() != 0), 32'd1);
         if (rsps.size() != 0) begin
            chk("rsp_addr", 32'(rsp_addr), 32'(rsps[0].addr));
            chk("rsp_data", 32'(rsp_data), 32'(rsps[0].data));
            if (rsp_ready) r = rsps.pop_front();
         end
      end
      if (req_valid && req_ready) begin
         o.wr   = req_wr;
         o.addr = req_addr;
         o.data = req_data;
         ops.push_back(o);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic wr, input logic [2:0] a, input logic [7:0] d);
      bit acc;
      acc       = 1'b0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_data  = d;
      for (int k = 0; k < 40 && !acc; k++) begin
         acc = req_ready;
         cycle();
      end
      req_valid = 1'b0;
      chk("req_accept", 32'(acc), 32'd1);
   endtask

   // Read into an idle block: strobe after edges N+1, N+2; response after N+3.
   task automatic read_lat(input logic [2:0] a, input logic [7:0] expd);
      int lat;
      lat = 0;
      send(1'b0, a, 8'h00);
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k <= 2) chk("rd_strobe", 32'(mem_r), 32'd1);
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_data", 32'(rsp_data), 32'(expd));
      chk("rd_addr", 32'(rsp_addr), 32'(a));
   endtask

   task automatic wait_rsp();
      for (int k = 0; k < 20 && !rsp_valid; k++) cycle();
      chk("rsp_seen", 32'(rsp_valid), 32'd1);
   endtask

   task automatic drain();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 100 && (busy || ops.size() != 0 || rsps.size() != 0); k++) cycle();
      cycle();
      chk("drain_busy", 32'(busy), 32'd0);
      chk("drain_ops", 32'(ops.size()), 32'd0);
      chk("drain_rsps", 32'(rsps.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
      chk({tag, "_mem_r"}, 32'(mem_r), 32'd0);
      chk({tag, "_mem_w"}, 32'(mem_w), 32'd0);
      chk({tag, "_mem_adr"}, 32'(mem_adr), 32'd0);
      chk({tag, "_mem_i"}, 32'(mem_i), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic release_reset();
      rstn = 1'b1;
      chk("ready_before_edge", 32'(req_ready), 32'd0);
      cycle();
      chk("ready_after_edge", 32'(req_ready), 32'd1);
      chk("busy_after_release", 32'(busy), 32'd0);
      ready_armed = 1'b1;
   endtask

   initial begin
      op_t tbl [5];
      int  wcnt;
      rstn        = 1'b1;
      req_valid   = 1'b0;
      req_wr      = 1'b0;
      req_addr    = '0;
      req_data    = '0;
      rsp_ready   = 1'b1;
      mem_clr     = 1'b1;
      phase       = 1'b0;
      ready_armed = 1'b0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;

      #2 rstn = 1'b0;
      #1 check_reset_outputs("reset");
      for (int i = 0; i < 3; i++) cycle();
      mem_clr = 1'b0;
      release_reset();

      // Two back-to-back writes: strobe held two cycles each, no response.
      send(1'b1, 3'd0, 8'd73);
      send(1'b1, 3'd1, 8'd97);
      wcnt = 0;
      for (int j = 0; j < 8; j++) begin
         if (j < 4) begin
            chk("wr_strobe", 32'(mem_w), 32'd1);
            chk("wr_adr", 32'(mem_adr), (j < 2) ? 32'd0 : 32'd1);
            chk("wr_data", 32'(mem_i), (j < 2) ? 32'd73 : 32'd97);
         end
         if (mem_w) wcnt++;
         chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
         cycle();
      end
      chk("wr_strobe_cycles", 32'(wcnt), 32'd4);

      read_lat(3'd0, 8'd73);
      read_lat(3'd1, 8'd97);

      // Write then immediate read of the same word.
      send(1'b1, 3'd2, 8'hA5);
      send(1'b0, 3'd2, 8'h00);
      wait_rsp();
      chk("raw_data", 32'(rsp_data), 32'hA5);
      chk("raw_addr", 32'(rsp_addr), 32'd2);
      drain();

      // Stalled response: FIFO fills to DEPTH, fifth request waits.
      rsp_ready = 1'b0;
      send(1'b0, 3'd1, 8'h00);
      wait_rsp();
      tbl[0] = '{wr: 1'b1, addr: 3'd3, data: 8'h11};
      tbl[1] = '{wr: 1'b0, addr: 3'd3, data: 8'h00};
      tbl[2] = '{wr: 1'b1, addr: 3'd4, data: 8'h22};
      tbl[3] = '{wr: 1'b0, addr: 3'd4, data: 8'h00};
      tbl[4] = '{wr: 1'b0, addr: 3'd0, data: 8'h00};
      for (int i = 0; i < 4; i++) send(tbl[i].wr, tbl[i].addr, tbl[i].data);
      chk("full_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1;
      req_wr    = tbl[4].wr;
      req_addr  = tbl[4].addr;
      req_data  = tbl[4].data;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("held_ready", 32'(req_ready), 32'd0);
         chk("held_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("held_rsp_data", 32'(rsp_data), 32'd97);
      end
      rsp_ready = 1'b1;
      send(tbl[4].wr, tbl[4].addr, tbl[4].data);
      drain();

      // Reset during CMD2 of a read with two requests queued.
      send(1'b0, 3'd5, 8'h00);
      send(1'b1, 3'd6, 8'h33);
      send(1'b1, 3'd7, 8'h44);
      chk("pre_reset_strobe", 32'(mem_r), 32'd1);
      #1 rstn = 1'b0;
      #1 check_reset_outputs("midop");
      ops.delete();
      rsps.delete();
      phase       = 1'b0;
      ready_armed = 1'b0;
      cycle();
      cycle();
      release_reset();
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("post_reset_idle", 32'(busy), 32'd0);
      end
      read_lat(3'd3, 8'h11);
      drain();

      // Random traffic with random response back-pressure.
      for (int k = 0; k < 400; k++) begin
         req_valid = ($urandom_range(0, 99) < 60);
         req_wr    = 1'($urandom_range(0, 1));
         req_addr  = 3'($urandom_range(0, 7));
         req_data  = 8'($urandom_range(0, 255));
         rsp_ready = ($urandom_range(0, 99) < 70);
         cycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
